aes128_iter_core: RTL and testbench



---
 rtl/aes_pkg.sv | 59 +++++
 rtl/aes_sbox.sv | 49 ++++
 rtl/aes128_iter_core.sv | 107 ++++++++++
 tb/tb_aes128_iter_core.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: block type, round constants and the linear
// round transforms (ShiftRows, MixColumns, RotWord).
package aes_pkg;

    // Byte i of a block (FIPS-197 order, column-major) lives in element [15-i].
    typedef logic [15:0][7:0] block_t;

    localparam logic [3:0] NR = 4'd10;

    // Indexed directly by the round counter; entries outside 1..10 are never used.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
        8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    function automatic block_t mix_columns(input block_t b);
        block_t o;
        for (int c = 0; c < 4; c++) begin
            o[15-4*c -: 4] = mix_column(b[15-4*c -: 4]);
        end
        return o;
    endfunction

    // Row r rotates left by r: out(r,c) = in(r,(c+r) mod 4).
    function automatic block_t shift_rows(input block_t b);
        block_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[15-(r+4*c)] = b[15-(r+4*((c+r)%4))];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the
// FIPS-197 affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a_i);
        y_o = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes128_iter_core.sv
// Free-running iterative AES-128 encryptor, one round per clock (11 clocks per
// block), with a saturating cumulative Hamming-distance counter on the output.
module aes128_iter_core
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic [63:0]  Capacitance
);

    logic [127:0] s_q,   s_d;
    logic [127:0] rk_q,  rk_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] out_q, out_d;
    logic [63:0]  cap_q, cap_d;

    logic [31:0]  rot_w;
    logic [31:0]  sub_w;
    logic [31:0]  t_w;
    logic [31:0]  w0_n, w1_n, w2_n, w3_n;
    logic [127:0] rk_n;
    logic [127:0] sb;
    block_t       sb_sr;
    block_t       mc;
    logic [127:0] res;
    logic [7:0]   pop;
    logic [64:0]  cap_sum;

    assign rot_w = rot_word(rk_q[31:0]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ks_sbox
            aes_sbox u_sbox (
                .a_i (rot_w[31-8*gi -: 8]),
                .y_o (sub_w[31-8*gi -: 8])
            );
        end
        for (genvar gi = 0; gi < 16; gi++) begin : g_st_sbox
            aes_sbox u_sbox (
                .a_i (s_q[127-8*gi -: 8]),
                .y_o (sb[127-8*gi -: 8])
            );
        end
    endgenerate

    always_comb begin
        t_w     = sub_w ^ {RCON[rnd_q], 24'h000000};
        w0_n    = rk_q[127:96] ^ t_w;
        w1_n    = rk_q[95:64]  ^ w0_n;
        w2_n    = rk_q[63:32]  ^ w1_n;
        w3_n    = rk_q[31:0]   ^ w2_n;
        rk_n    = {w0_n, w1_n, w2_n, w3_n};
        sb_sr   = shift_rows(sb);
        mc      = mix_columns(sb_sr);
        res     = sb_sr ^ rk_n;
        pop     = 8'($countones(out_q ^ res));
        cap_sum = {1'b0, cap_q} + {57'd0, pop};
    end

    always_comb begin
        s_d   = s_q;
        rk_d  = rk_q;
        rnd_d = rnd_q;
        out_d = out_q;
        cap_d = cap_q;
        case (rnd_q)
            4'd0: begin
                s_d   = state ^ key;
                rk_d  = key;
                rnd_d = 4'd1;
            end
            NR: begin
                out_d = res;
                cap_d = cap_sum[64] ? {64{1'b1}} : cap_sum[63:0];
                rnd_d = 4'd0;
            end
            default: begin
                s_d   = mc ^ rk_n;
                rk_d  = rk_n;
                rnd_d = rnd_q + 4'd1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q   <= '0;
            rk_q  <= '0;
            rnd_q <= '0;
            out_q <= '0;
            cap_q <= '0;
        end else begin
            s_q   <= s_d;
            rk_q  <= rk_d;
            rnd_q <= rnd_d;
            out_q <= out_d;
            cap_q <= cap_d;
        end
    end

    assign out         = out_q;
    assign Capacitance = cap_q;

endmodule

// File: tb/tb_aes128_iter_core.sv
// Scoreboard bench for aes128_iter_core: published AES-128 vectors, output
// hold/latency, input isolation, async reset and counter saturation.
module tb_aes128_iter_core;

    localparam logic [127:0] ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] SP_PT    = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] SP_CT    = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [63:0]  SAT_START = 64'hffff_ffff_ffff_fff0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] state;
    logic [127:0] key;
    logic [127:0] out;
    logic [63:0]  cap;

    typedef struct {
        logic [127:0] ct;
        logic [63:0]  cap;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [127:0] model_out;
    logic [63:0]  model_cap;

    aes128_iter_core dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .key         (key),
        .out         (out),
        .Capacitance (cap)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%032h expected=%032h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] ct);
        logic [64:0] sum;
        sum       = {1'b0, model_cap} + 65'($countones(model_out ^ ct));
        model_cap = sum[64] ? {64{1'b1}} : sum[63:0];
        model_out = ct;
        sb_q.push_back('{ct: ct, cap: model_cap});
    endtask

    // Called between edges, just before a load edge.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] ct, input bit garble, input bit sat_force);
        logic [127:0] prev_out;
        exp_t         e;
        prev_out = model_out;
        state    = pt;
        key      = k;
        if (sat_force) model_cap = SAT_START;
        push_exp(ct);
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk);
            #1;
            if (garble && n == 3) begin
                state = {4{$urandom()}};
                key   = {4{$urandom()}};
            end
            if (sat_force && n == 5) force dut.cap_q = SAT_START;
            if (sat_force && n == 6) release dut.cap_q;
            if (n == 10) chk({tag, "_hold"}, out, prev_out);
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 128'd0, 128'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ct"}, out, e.ct);
            chk({tag, "_cap"}, {64'd0, cap}, {64'd0, e.cap});
            $display("blk %-8s out=%032h cap=%016h exp_cap=%016h", tag, out, cap, e.cap);
        end
    endtask

    initial begin
        state = {4{$urandom()}};
        key   = {4{$urandom()}};
        rst   = 1'b0;
        model_out = '0;
        model_cap = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", out, 128'd0);
        chk("rst_cap", {64'd0, cap}, 128'd0);
        $display("rst      out=%032h cap=%016h", out, cap);

        rst = 1'b1;
        run_block("zero",  128'd0, 128'd0, ZERO_CT, 1'b0, 1'b0);
        chk("zero_cap65", {64'd0, cap}, 128'd65);
        run_block("zero2", 128'd0, 128'd0, ZERO_CT, 1'b0, 1'b0);
        run_block("c1",    C1_PT,  C1_KEY, C1_CT,   1'b1, 1'b0);
        run_block("appb",  B_PT,   B_KEY,  B_CT,    1'b1, 1'b0);
        run_block("sp_sat", SP_PT, B_KEY,  SP_CT,   1'b0, 1'b1);
        chk("sat_max", {64'd0, cap}, {64'd0, {64{1'b1}}});
        run_block("c1_sat", C1_PT, C1_KEY, C1_CT,   1'b0, 1'b0);

        // Abort a block mid-flight: reset must act without a clock edge.
        state = B_PT;
        key   = B_KEY;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_out", out, 128'd0);
        chk("abort_cap", {64'd0, cap}, 128'd0);
        $display("abort    out=%032h cap=%016h", out, cap);
        model_out = '0;
        model_cap = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_block("post_rst", C1_PT, C1_KEY, C1_CT, 1'b0, 1'b0);

        chk("sb_empty", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
